// File: rtl/lcd_image_controller_pkg.sv
// Shared image-spec helpers, LCD command codes and state encodings for the
// 8080-style LCD image controller.
package lcd_image_controller_pkg;

  // Image spec word: {r_width, g_width, b_width, reserved}, one byte each.
  typedef logic [31:0] image_spec_t;

  localparam image_spec_t IsRgb565 = {8'd5, 8'd6, 8'd5, 8'd0};

  function automatic int is_r_w(input image_spec_t spec);
    return int'(spec[31:24]);
  endfunction

  function automatic int is_g_w(input image_spec_t spec);
    return int'(spec[23:16]);
  endfunction

  function automatic int is_b_w(input image_spec_t spec);
    return int'(spec[15:8]);
  endfunction

  function automatic int i_w(input image_spec_t spec);
    return is_r_w(spec) + is_g_w(spec) + is_b_w(spec);
  endfunction

  function automatic logic [31:0] is_field(input logic [31:0] word, input int lsb, input int w);
    return (word >> lsb) & ((32'd1 << w) - 32'd1);
  endfunction

  // Wider fields keep their MSBs; narrower fields are left-aligned.
  function automatic logic [31:0] fit_msbs(input logic [31:0] f, input int from_w, input int to_w);
    return (from_w >= to_w) ? (f >> (from_w - to_w)) : (f << (to_w - from_w));
  endfunction

  function automatic logic [15:0] pack_rgb565(input image_spec_t spec, input logic [31:0] word);
    logic [31:0] r, g, b;
    int rw, gw, bw;
    rw = is_r_w(spec);
    gw = is_g_w(spec);
    bw = is_b_w(spec);
    r = fit_msbs(is_field(word, gw + bw, rw), rw, 5);
    g = fit_msbs(is_field(word, bw, gw), gw, 6);
    b = fit_msbs(is_field(word, 0, bw), bw, 5);
    return {r[4:0], g[5:0], b[4:0]};
  endfunction

  typedef enum logic [2:0] {
    CmdSoftReset, CmdSleepOut, CmdPixelFormat, CmdMemAccess,
    CmdDisplayOn, CmdColumnAddr, CmdPageAddr, CmdMemWrite
  } lcd_cmd_e;

  function automatic logic [7:0] lcd_cmd_byte(input lcd_cmd_e c);
    case (c)
      CmdSoftReset:   return 8'h01;
      CmdSleepOut:    return 8'h11;
      CmdPixelFormat: return 8'h3A;
      CmdMemAccess:   return 8'h36;
      CmdDisplayOn:   return 8'h29;
      CmdColumnAddr:  return 8'h2A;
      CmdPageAddr:    return 8'h2B;
      default:        return 8'h2C;
    endcase
  endfunction

  typedef enum logic [2:0] {
    ResetHold, ResetRelease, Configure, Idle, Window, Stream
  } lcd_state_e;

  typedef enum logic [1:0] {BusIdle, BusLow, BusHigh} bus_state_e;

endpackage

// File: rtl/lcd_image_controller_if.sv
// Image pipe bundle between an image source (master) and the LCD controller (slave).
interface lcd_image_controller_if
  import lcd_image_controller_pkg::*;
#(parameter int W = i_w(IsRgb565)) ();

  logic [W-1:0] data;
  logic         start;
  logic         stop;
  logic         valid;
  logic         request;
  logic         ready;

  modport master (output data, start, stop, valid, input request, ready);
  modport slave  (input data, start, stop, valid, output request, ready);

endinterface

// File: rtl/lcd_image_controller_bus_writer.sv
// One 8080 write cycle per strobe: wr low for TimerCount clocks, then high for
// TimerCount clocks, with cs/rs/db held stable for the whole cycle.
module lcd_bus_writer
  import lcd_image_controller_pkg::*;
#(parameter int TimerCount = 2)
(
  input  logic        clock,
  input  logic        reset,
  input  logic        strobe,
  input  logic        is_data,
  input  logic [15:0] value,
  input  logic        deselect,
  output logic        ready,
  output logic [17:0] lcd_db,
  output logic        lcd_wr,
  output logic        lcd_rs,
  output logic        lcd_cs
);

  bus_state_e state;
  logic [7:0] timer;

  assign ready = (state == BusIdle);

  // cs stays low between back-to-back words and only rises when the owner deselects.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= BusIdle;
      timer  <= '0;
      lcd_db <= '0;
      lcd_wr <= 1'b1;
      lcd_rs <= 1'b0;
      lcd_cs <= 1'b1;
    end else begin
      case (state)
        BusIdle: begin
          if (strobe) begin
            lcd_db <= {2'b00, value};
            lcd_rs <= is_data;
            lcd_cs <= 1'b0;
            lcd_wr <= 1'b0;
            timer  <= '0;
            state  <= BusLow;
          end else if (deselect) begin
            lcd_cs <= 1'b1;
          end
        end
        BusLow: begin
          if (timer == 8'(TimerCount - 1)) begin
            lcd_wr <= 1'b1;
            timer  <= '0;
            state  <= BusHigh;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        BusHigh: begin
          if (timer == 8'(TimerCount - 1)) begin
            timer <= '0;
            state <= BusIdle;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= BusIdle;
      endcase
    end
  end

endmodule

// File: rtl/lcd_image_controller.sv
// Configures an 8080-style LCD after reset, then on each refresh pulse sets a
// full-screen window and streams LcdWidth*LcdHeight pixels from the image pipe.
module lcd_image_controller
  import lcd_image_controller_pkg::*;
#(
  parameter image_spec_t IS                       = IsRgb565,
  parameter int          LcdWidth                 = 480,
  parameter int          LcdHeight                = 320,
  parameter int          LcdCoordinateWidth       = 9,
  parameter int          LcdCommandWidth          = 3,
  parameter int          LcdPixelWidth            = 16,
  parameter int          LcdCommandDataTimerCount = 2,
  parameter int          LcdDelayTimerCount       = 100
)
(
  input  logic                         clock,
  input  logic                         reset,
  output logic                         configuring,
  output logic                         running,
  output logic                         busy,
  lcd_image_controller_if.slave        image,
  input  logic                         refresh,
  output logic [17:0]                  lcd_db,
  output logic                         lcd_rd,
  output logic                         lcd_wr,
  output logic                         lcd_rs,
  output logic                         lcd_cs,
  output logic                         lcd_id,
  output logic                         lcd_rst,
  input  logic                         lcd_fmark,
  output logic                         lcd_blen
);

  typedef struct packed {
    logic                       delay;
    logic                       is_data;
    logic [LcdCommandWidth-1:0] code;
    logic [7:0]                 data;
  } step_t;

  function automatic step_t config_step(input logic [3:0] s);
    step_t e;
    e = '0;
    case (s)
      4'd0:    begin e.code = LcdCommandWidth'(CmdSoftReset); e.delay = 1'b1; end
      4'd1:    begin e.code = LcdCommandWidth'(CmdSleepOut);  e.delay = 1'b1; end
      4'd2:    e.code = LcdCommandWidth'(CmdPixelFormat);
      4'd3:    begin e.is_data = 1'b1; e.data = 8'h55; end
      4'd4:    e.code = LcdCommandWidth'(CmdMemAccess);
      4'd5:    begin e.is_data = 1'b1; e.data = 8'h00; end
      default: e.code = LcdCommandWidth'(CmdDisplayOn);
    endcase
    return e;
  endfunction

  function automatic step_t window_step(input logic [3:0] s);
    step_t e;
    logic [15:0] x1, y1;
    x1 = 16'(LcdWidth - 1);
    y1 = 16'(LcdHeight - 1);
    e = '0;
    e.is_data = 1'b1;
    case (s)
      4'd0:    begin e.is_data = 1'b0; e.code = LcdCommandWidth'(CmdColumnAddr); end
      4'd3:    e.data = x1[15:8];
      4'd4:    e.data = x1[7:0];
      4'd5:    begin e.is_data = 1'b0; e.code = LcdCommandWidth'(CmdPageAddr); end
      4'd8:    e.data = y1[15:8];
      4'd9:    e.data = y1[7:0];
      4'd10:   begin e.is_data = 1'b0; e.code = LcdCommandWidth'(CmdMemWrite); end
      default: e.data = 8'h00;
    endcase
    return e;
  endfunction

  lcd_state_e                    state;
  logic [15:0]                   timer;
  logic [3:0]                    step;
  logic                          seq_done;
  logic                          delay_pending;
  logic [LcdCoordinateWidth-1:0] x_pos, y_pos;
  logic                          image_request;

  step_t                         entry;
  logic [7:0]                    entry_byte;
  logic                          seq_issue, seq_last, stream_ready, bus_ready, bus_strobe;
  logic [15:0]                   bus_value;
  logic [LcdPixelWidth-1:0]      pixel;
  logic                          unused_inputs;

  assign lcd_rd        = 1'b1;
  assign lcd_id        = 1'b0;
  assign unused_inputs = &{1'b0, image.start, image.stop, lcd_fmark};

  assign entry        = (state == Window) ? window_step(step) : config_step(step);
  assign entry_byte   = entry.is_data ? entry.data : lcd_cmd_byte(lcd_cmd_e'(entry.code));
  assign seq_last     = (state == Window) ? (step == 4'd10) : (step == 4'd6);
  assign seq_issue    = ((state == Configure) || (state == Window)) && bus_ready && !delay_pending && !seq_done;
  assign stream_ready = (state == Stream) && bus_ready;
  assign pixel        = LcdPixelWidth'(pack_rgb565(IS, 32'(image.data)));
  assign bus_strobe   = seq_issue || (stream_ready && image.valid);
  assign bus_value    = (state == Stream) ? 16'(pixel) : {8'h00, entry_byte};

  assign image.ready   = stream_ready;
  assign image.request = image_request;

  lcd_bus_writer #(.TimerCount(LcdCommandDataTimerCount)) u_bus_writer (
    .clock    (clock),
    .reset    (reset),
    .strobe   (bus_strobe),
    .is_data  ((state == Stream) ? 1'b1 : entry.is_data),
    .value    (bus_value),
    .deselect (state == Idle),
    .ready    (bus_ready),
    .lcd_db   (lcd_db),
    .lcd_wr   (lcd_wr),
    .lcd_rs   (lcd_rs),
    .lcd_cs   (lcd_cs)
  );

  // Configure and Window share one sequencer: issue a step, optionally wait a delay
  // after the write finishes, and leave only once the final write has drained.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ResetHold;
      timer         <= '0;
      step          <= '0;
      seq_done      <= 1'b0;
      delay_pending <= 1'b0;
      x_pos         <= '0;
      y_pos         <= '0;
      image_request <= 1'b0;
      configuring   <= 1'b0;
      running       <= 1'b0;
      busy          <= 1'b1;
      lcd_rst       <= 1'b0;
      lcd_blen      <= 1'b0;
    end else begin
      case (state)
        ResetHold, ResetRelease: begin
          if (timer == 16'(LcdDelayTimerCount - 1)) begin
            timer <= '0;
            if (state == ResetHold) begin
              lcd_rst <= 1'b1;
              state   <= ResetRelease;
            end else begin
              configuring <= 1'b1;
              step        <= '0;
              state       <= Configure;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        Configure, Window: begin
          image_request <= 1'b0;
          if (seq_issue) begin
            if (seq_last) seq_done <= 1'b1;
            else          step     <= step + 4'd1;
            delay_pending <= entry.delay;
            timer         <= '0;
          end else if (delay_pending && bus_ready) begin
            if (timer == 16'(LcdDelayTimerCount - 1)) begin
              delay_pending <= 1'b0;
              timer         <= '0;
            end else begin
              timer <= timer + 16'd1;
            end
          end else if (seq_done && bus_ready) begin
            seq_done <= 1'b0;
            step     <= '0;
            if (state == Configure) begin
              configuring <= 1'b0;
              running     <= 1'b1;
              lcd_blen    <= 1'b1;
              busy        <= 1'b0;
              state       <= Idle;
            end else begin
              x_pos <= '0;
              y_pos <= '0;
              state <= Stream;
            end
          end
        end
        Idle: begin
          if (refresh) begin
            busy          <= 1'b1;
            image_request <= 1'b1;
            step          <= '0;
            state         <= Window;
          end
        end
        Stream: begin
          if (stream_ready && image.valid) begin
            if (x_pos == LcdCoordinateWidth'(LcdWidth - 1)) begin
              x_pos <= '0;
              if (y_pos == LcdCoordinateWidth'(LcdHeight - 1)) begin
                busy  <= 1'b0;
                state <= Idle;
              end else begin
                y_pos <= y_pos + 1'b1;
              end
            end else begin
              x_pos <= x_pos + 1'b1;
            end
          end
        end
        default: state <= ResetHold;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_image_controller.sv
// Directed bench for lcd_image_controller on a 32x16 panel with a 8/8/8 image source
// and a bus proxy that logs every write latched on the rising edge of lcd_wr.
module tb_lcd_image_controller;
  import lcd_image_controller_pkg::*;

  localparam image_spec_t TbIs = {8'd8, 8'd8, 8'd8, 8'd0};
  localparam int Width  = 32;
  localparam int Height = 16;
  localparam int Pixels = Width * Height;

  logic        clock;
  logic        reset;
  logic        configuring, running, busy, refresh;
  logic [17:0] lcd_db;
  logic        lcd_rd, lcd_wr, lcd_rs, lcd_cs, lcd_id, lcd_rst, lcd_fmark, lcd_blen;

  lcd_image_controller_if #(.W(i_w(TbIs))) img ();

  lcd_image_controller #(
    .IS(TbIs), .LcdWidth(Width), .LcdHeight(Height), .LcdCoordinateWidth(9),
    .LcdCommandWidth(3), .LcdPixelWidth(16), .LcdCommandDataTimerCount(2),
    .LcdDelayTimerCount(100)
  ) dut (
    .clock(clock), .reset(reset), .configuring(configuring), .running(running),
    .busy(busy), .image(img), .refresh(refresh), .lcd_db(lcd_db), .lcd_rd(lcd_rd),
    .lcd_wr(lcd_wr), .lcd_rs(lcd_rs), .lcd_cs(lcd_cs), .lcd_id(lcd_id),
    .lcd_rst(lcd_rst), .lcd_fmark(lcd_fmark), .lcd_blen(lcd_blen)
  );

  int          checks = 0;
  int          failures = 0;
  logic [18:0] cap [$];
  bit          capture_en = 0;
  int          src_mode = 0;
  int          src_index = 0;
  bit          src_on = 0;
  bit          src_stall = 0;
  bit          accept_pending = 0;
  int          n, held, wr_low;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [23:0] src_word(input int mode, input int idx);
    if (mode == 0) return 24'hFFFFFF;
    return {8'(idx * 3), 8'(idx * 5 + 7), 8'(idx) ^ 8'hA5};
  endfunction

  function automatic logic [15:0] exp_pixel(input int mode, input int idx);
    logic [23:0] d;
    d = src_word(mode, idx);
    return {d[23:19], d[15:10], d[7:3]};
  endfunction

  function automatic logic [18:0] exp_entry(input logic rs, input logic [15:0] v);
    return {rs, 2'b00, v};
  endfunction

  function automatic logic [18:0] cfg_expect(input int i);
    case (i)
      0: return exp_entry(1'b0, 16'h01);
      1: return exp_entry(1'b0, 16'h11);
      2: return exp_entry(1'b0, 16'h3A);
      3: return exp_entry(1'b1, 16'h55);
      4: return exp_entry(1'b0, 16'h36);
      5: return exp_entry(1'b1, 16'h00);
      default: return exp_entry(1'b0, 16'h29);
    endcase
  endfunction

  function automatic logic [18:0] win_expect(input int i);
    case (i)
      0: return exp_entry(1'b0, 16'h2A);
      4: return exp_entry(1'b1, 16'h1F);
      5: return exp_entry(1'b0, 16'h2B);
      9: return exp_entry(1'b1, 16'h0F);
      10: return exp_entry(1'b0, 16'h2C);
      default: return exp_entry(1'b1, 16'h00);
    endcase
  endfunction

  function automatic logic [18:0] cap_at(input int i);
    if (i < cap.size()) return cap[i];
    return '1;
  endfunction

  always @(posedge lcd_wr) begin
    if (capture_en && lcd_cs === 1'b0) cap.push_back({lcd_rs, lcd_db});
  end

  // Source changes data only on negedges and books an acceptance for the coming posedge.
  always @(negedge clock) begin
    if (accept_pending) src_index++;
    img.data  = src_word(src_mode, src_index);
    img.start = (src_index == 0);
    img.stop  = (src_index == Pixels - 1);
    img.valid = src_on && !src_stall;
    accept_pending = img.valid && (img.ready === 1'b1);
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input string tag);
    cap.delete();
    src_index = 0;
    @(negedge clock);
    refresh = 1'b1;
    @(negedge clock);
    refresh = 1'b0;
    check_output({tag, "_busy_rise"}, 32'(busy), 32'd1);
    check_output({tag, "_request_pulse"}, 32'(img.request), 32'd1);
    @(negedge clock);
    check_output({tag, "_request_drop"}, 32'(img.request), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_ctrl"},
      32'({configuring, running, busy, lcd_rst, lcd_cs, lcd_wr, lcd_rd, lcd_rs, lcd_blen, img.request, img.ready}),
      32'(11'b0_0_1_0_1_1_1_0_0_0_0));
    check_output({tag, "_db"}, 32'(lcd_db), 32'd0);
  endtask

  task automatic wait_running(input string tag);
    n = 0;
    while (running !== 1'b1 && n < 1000) begin @(negedge clock); n++; end
    check_output({tag, "_running_in_budget"}, 32'(n < 1000), 32'd1);
    repeat (3) @(negedge clock);
    check_output({tag, "_idle_flags"}, 32'({configuring, running, busy, lcd_blen, lcd_cs}), 32'(5'b0_1_0_1_1));
    check_output({tag, "_cfg_length"}, 32'(cap.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      check_output($sformatf("%s_cfg%0d", tag, i), 32'(cap_at(i)), 32'(cfg_expect(i)));
  endtask

  task automatic wait_frame(input string tag);
    n = 0;
    while (busy !== 1'b0 && n < 20000) begin @(negedge clock); n++; end
    check_output({tag, "_done_in_budget"}, 32'(n < 20000), 32'd1);
    repeat (10) @(negedge clock);
  endtask

  task automatic check_frame(input string tag, input int mode);
    int bad;
    check_output({tag, "_length"}, 32'(cap.size()), 32'(11 + Pixels));
    for (int i = 0; i < 11; i++)
      check_output($sformatf("%s_hdr%0d", tag, i), 32'(cap_at(i)), 32'(win_expect(i)));
    bad = 0;
    for (int p = 0; p < Pixels; p++)
      if (cap_at(11 + p) !== exp_entry(1'b1, exp_pixel(mode, p))) bad++;
    check_output({tag, "_bad_pixels"}, 32'(bad), 32'd0);
    check_output({tag, "_cs_idle"}, 32'(lcd_cs), 32'd1);
  endtask

  initial begin
    $display("[TB] lcd_image_controller bench start");
    reset = 1'b0;
    refresh = 1'b0;
    lcd_fmark = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset0");
    check_output("lcd_id", 32'(lcd_id), 32'd0);

    capture_en = 1;
    reset = 1'b1;
    n = 0;
    while (lcd_rst === 1'b0 && n < 1000) begin @(negedge clock); n++; end
    check_output("rst_low_clocks", 32'(n), 32'd100);

    n = 0;
    while (configuring !== 1'b1 && n < 1000) begin @(negedge clock); n++; end
    check_output("configuring_rise", 32'(configuring), 32'd1);
    refresh = 1'b1;
    @(negedge clock);
    refresh = 1'b0;
    @(negedge clock);
    check_output("refresh_in_config_ignored", 32'(img.request), 32'd0);
    wait_running("boot");

    src_on = 1;
    src_mode = 0;
    apply_stimulus("frame1");
    wait_frame("frame1");
    check_frame("frame1", 0);

    apply_stimulus("frame2");
    wait_frame("frame2");
    check_frame("frame2", 0);

    src_mode = 1;
    apply_stimulus("frame3");
    n = 0;
    while (src_index < 100 && n < 20000) begin @(negedge clock); n++; end
    src_stall = 1;
    repeat (8) @(negedge clock);
    held = src_index;
    wr_low = 0;
    repeat (50) begin
      @(negedge clock);
      if (lcd_wr !== 1'b1) wr_low++;
    end
    check_output("stall_wr_high", 32'(wr_low), 32'd0);
    check_output("stall_no_consume", 32'(src_index), 32'(held));
    src_stall = 0;
    wait_frame("frame3");
    check_frame("frame3", 1);
    check_output("frame3_pixel0", 32'(cap_at(11)), 32'(exp_entry(1'b1, 16'h0034)));
    check_output("frame3_pixel1", 32'(cap_at(12)), 32'(exp_entry(1'b1, 16'h0074)));

    apply_stimulus("abort");
    n = 0;
    while (src_index < 50 && n < 20000) begin @(negedge clock); n++; end
    capture_en = 0;
    src_on = 0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset_mid");
    cap.delete();
    capture_en = 1;
    reset = 1'b1;
    n = 0;
    while (lcd_rst === 1'b0 && n < 1000) begin @(negedge clock); n++; end
    check_output("rst_low_clocks_again", 32'(n), 32'd100);
    wait_running("reboot");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
